// File: rtl/alarm_clock_controller.sv
// alarm_clock_controller: mode/adjust controller for the digital alarm clock.
// Arbitrates the debounced buttons, steps the timekeeping counter while it is
// paused for adjustment, owns the alarm time and enable bit, and drives the
// ringing output including its self-timeout.
module alarm_clock_controller #(
  parameter int RING_SECS   = 60,
  parameter int ALM_HR_RST  = 0,
  parameter int ALM_MIN_RST = 0
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       up,
  input  logic       down,
  input  logic       left,
  input  logic       right,
  input  logic       center,
  input  logic       tick_1hz,
  input  logic       alarm_match,
  output logic       run_en,
  output logic       adj_mode,
  output logic [1:0] sel,
  output logic       clk_hr_inc,
  output logic       clk_hr_dec,
  output logic       clk_min_inc,
  output logic       clk_min_dec,
  output logic [4:0] alm_hr,
  output logic [5:0] alm_min,
  output logic       alarm_en,
  output logic       ringing
);

  localparam int CW = (RING_SECS < 2) ? 1 : $clog2(RING_SECS + 1);

  typedef enum logic {
    RUN    = 1'b0,
    ADJUST = 1'b1
  } state_t;

  state_t          state;
  logic            match_d;
  logic [CW-1:0]   ring_cnt;
  logic            btn_c, btn_r, btn_l, btn_u, btn_d, any_btn;
  logic            match_rise;

  // Fixed-priority pick so exactly one button is acted on per cycle
  always_comb begin
    btn_c      = center;
    btn_r      = right & ~center;
    btn_l      = left  & ~center & ~right;
    btn_u      = up    & ~center & ~right & ~left;
    btn_d      = down  & ~center & ~right & ~left & ~up;
    any_btn    = center | right | left | up | down;
    match_rise = alarm_match & ~match_d;
  end

  // Mode FSM with registered outputs; alarm registers and ring timer live here too
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state       <= RUN;
      run_en      <= 1'b1;
      adj_mode    <= 1'b0;
      sel         <= 2'd0;
      clk_hr_inc  <= 1'b0;
      clk_hr_dec  <= 1'b0;
      clk_min_inc <= 1'b0;
      clk_min_dec <= 1'b0;
      alm_hr      <= 5'(ALM_HR_RST);
      alm_min     <= 6'(ALM_MIN_RST);
      alarm_en    <= 1'b0;
      ringing     <= 1'b0;
      ring_cnt    <= '0;
      match_d     <= 1'b0;
    end else begin
      match_d     <= alarm_match;
      clk_hr_inc  <= 1'b0;
      clk_hr_dec  <= 1'b0;
      clk_min_inc <= 1'b0;
      clk_min_dec <= 1'b0;
      case (state)
        RUN: begin
          if (ringing) begin
            // Any button only silences the alarm; the pulse is consumed here
            if (any_btn) begin
              ringing  <= 1'b0;
              ring_cnt <= '0;
            end else if (tick_1hz) begin
              if (ring_cnt == CW'(RING_SECS - 1)) begin
                ringing  <= 1'b0;
                ring_cnt <= '0;
              end else begin
                ring_cnt <= ring_cnt + 1'b1;
              end
            end
          end else if (btn_c) begin
            // Entering ADJUST takes priority over a coincident match edge
            state    <= ADJUST;
            run_en   <= 1'b0;
            adj_mode <= 1'b1;
          end else begin
            if (btn_u) begin
              alarm_en <= 1'b1;
            end else if (btn_d) begin
              alarm_en <= 1'b0;
            end
            // The enable as it stood before this cycle's button decides arming
            if (match_rise && alarm_en) begin
              ringing <= 1'b1;
            end
          end
        end
        ADJUST: begin
          if (btn_c) begin
            state    <= RUN;
            run_en   <= 1'b1;
            adj_mode <= 1'b0;
          end else if (btn_r) begin
            sel <= sel + 2'd1;
          end else if (btn_l) begin
            sel <= sel - 2'd1;
          end else if (btn_u || btn_d) begin
            case (sel)
              2'd0: begin
                clk_hr_inc <= btn_u;
                clk_hr_dec <= btn_d;
              end
              2'd1: begin
                clk_min_inc <= btn_u;
                clk_min_dec <= btn_d;
              end
              2'd2: begin
                if (btn_u) alm_hr <= (alm_hr == 5'd23) ? 5'd0 : alm_hr + 5'd1;
                else       alm_hr <= (alm_hr == 5'd0) ? 5'd23 : alm_hr - 5'd1;
              end
              default: begin
                if (btn_u) alm_min <= (alm_min == 6'd59) ? 6'd0 : alm_min + 6'd1;
                else       alm_min <= (alm_min == 6'd0) ? 6'd59 : alm_min - 6'd1;
              end
            endcase
          end
        end
        default: begin
          state <= RUN;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_alarm_clock_controller.sv
// tb_alarm_clock_controller: directed scenarios followed by random button,
// tick and match traffic, all compared against a behavioural model of the
// clock controller kept in plain integer arithmetic.
module tb_alarm_clock_controller;

  localparam int RING_SECS   = 3;
  localparam int ALM_HR_RST  = 0;
  localparam int ALM_MIN_RST = 0;

  localparam logic [4:0] B_NONE = 5'b00000;
  localparam logic [4:0] B_C    = 5'b10000;
  localparam logic [4:0] B_R    = 5'b01000;
  localparam logic [4:0] B_L    = 5'b00100;
  localparam logic [4:0] B_U    = 5'b00010;
  localparam logic [4:0] B_D    = 5'b00001;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       up = 1'b0, down = 1'b0, left = 1'b0, right = 1'b0, center = 1'b0;
  logic       tick_1hz = 1'b0, alarm_match = 1'b0;
  logic       run_en, adj_mode;
  logic [1:0] sel;
  logic       clk_hr_inc, clk_hr_dec, clk_min_inc, clk_min_dec;
  logic [4:0] alm_hr;
  logic [5:0] alm_min;
  logic       alarm_en, ringing;

  int checks = 0;
  int errors = 0;

  // Behavioural model state
  int m_adj, m_sel, m_hr, m_min, m_en, m_ring, m_cnt, m_prev_match;
  int m_hinc, m_hdec, m_minc, m_mdec;

  alarm_clock_controller #(
    .RING_SECS  (RING_SECS),
    .ALM_HR_RST (ALM_HR_RST),
    .ALM_MIN_RST(ALM_MIN_RST)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .up         (up),
    .down       (down),
    .left       (left),
    .right      (right),
    .center     (center),
    .tick_1hz   (tick_1hz),
    .alarm_match(alarm_match),
    .run_en     (run_en),
    .adj_mode   (adj_mode),
    .sel        (sel),
    .clk_hr_inc (clk_hr_inc),
    .clk_hr_dec (clk_hr_dec),
    .clk_min_inc(clk_min_inc),
    .clk_min_dec(clk_min_dec),
    .alm_hr     (alm_hr),
    .alm_min    (alm_min),
    .alarm_en   (alarm_en),
    .ringing    (ringing)
  );

  always #5 clk = ~clk;

  task automatic checkOutput(input string tag, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s actual=%0d expected=%0d at %0t", tag, act, exp, $time);
    end
  endtask

  task automatic resetModel();
    m_adj = 0; m_sel = 0; m_hr = ALM_HR_RST; m_min = ALM_MIN_RST;
    m_en = 0; m_ring = 0; m_cnt = 0; m_prev_match = 0;
    m_hinc = 0; m_hdec = 0; m_minc = 0; m_mdec = 0;
  endtask

  // One clock of the controller's rules, written from the user's point of view
  task automatic modelStep(input logic [4:0] b, input logic t, input logic m);
    int edge_seen;
    int pick;
    edge_seen = (m == 1'b1 && m_prev_match == 0) ? 1 : 0;
    m_prev_match = int'(m);
    m_hinc = 0; m_hdec = 0; m_minc = 0; m_mdec = 0;
    pick = 0;
    for (int i = 4; i >= 0; i--) begin
      if (pick == 0 && b[i]) pick = i + 1;
    end
    // pick: 5=center 4=right 3=left 2=up 1=down 0=none
    if (m_adj == 0) begin
      if (m_ring != 0) begin
        if (pick != 0) begin
          m_ring = 0; m_cnt = 0;
        end else if (t) begin
          m_cnt++;
          if (m_cnt >= RING_SECS) begin
            m_ring = 0; m_cnt = 0;
          end
        end
      end else if (pick == 5) begin
        m_adj = 1;
      end else begin
        if (edge_seen != 0 && m_en != 0) m_ring = 1;
        if (pick == 2) m_en = 1;
        else if (pick == 1) m_en = 0;
      end
    end else begin
      case (pick)
        5: m_adj = 0;
        4: m_sel = (m_sel + 1) % 4;
        3: m_sel = (m_sel + 3) % 4;
        2, 1: begin
          case (m_sel)
            0: if (pick == 2) m_hinc = 1; else m_hdec = 1;
            1: if (pick == 2) m_minc = 1; else m_mdec = 1;
            2: m_hr  = (pick == 2) ? (m_hr + 1) % 24 : (m_hr + 23) % 24;
            default: m_min = (pick == 2) ? (m_min + 1) % 60 : (m_min + 59) % 60;
          endcase
        end
        default: ;
      endcase
    end
  endtask

  task automatic checkAll(input string tag);
    checkOutput({tag, ".run_en"},   32'(run_en),      32'(m_adj == 0));
    checkOutput({tag, ".adj_mode"}, 32'(adj_mode),    32'(m_adj));
    checkOutput({tag, ".sel"},      32'(sel),         32'(m_sel));
    checkOutput({tag, ".hr_inc"},   32'(clk_hr_inc),  32'(m_hinc));
    checkOutput({tag, ".hr_dec"},   32'(clk_hr_dec),  32'(m_hdec));
    checkOutput({tag, ".min_inc"},  32'(clk_min_inc), 32'(m_minc));
    checkOutput({tag, ".min_dec"},  32'(clk_min_dec), 32'(m_mdec));
    checkOutput({tag, ".alm_hr"},   32'(alm_hr),      32'(m_hr));
    checkOutput({tag, ".alm_min"},  32'(alm_min),     32'(m_min));
    checkOutput({tag, ".alarm_en"}, 32'(alarm_en),    32'(m_en));
    checkOutput({tag, ".ringing"},  32'(ringing),     32'(m_ring));
  endtask

  // Drive one cycle of inputs, let the edge happen, then compare everything
  task automatic applyStimulus(input string tag, input logic [4:0] b, input logic t, input logic m);
    {center, right, left, up, down} = b;
    tick_1hz    = t;
    alarm_match = m;
    @(posedge clk);
    modelStep(b, t, m);
    #1;
    {center, right, left, up, down} = B_NONE;
    tick_1hz = 1'b0;
    checkAll(tag);
  endtask

  task automatic asyncReset(input string tag);
    #2;
    rst = 1'b0;
    resetModel();
    #1;
    checkAll(tag);
    @(negedge clk);
    rst = 1'b1;
  endtask

  initial begin
    logic [4:0] rb;
    logic       rm;
    resetModel();
    rst = 1'b0;
    #12;
    checkAll("reset");
    checkOutput("reset.alm_hr_const", 32'(alm_hr), 32'(ALM_HR_RST));
    @(negedge clk);
    rst = 1'b1;

    // Enter adjust, select alarm hour, bump it three times, leave
    applyStimulus("enter", B_C, 0, 0);
    applyStimulus("sel1",  B_R, 0, 0);
    applyStimulus("sel2",  B_R, 0, 0);
    repeat (3) applyStimulus("hr_up", B_U, 0, 0);
    checkOutput("plan1.adj", 32'(adj_mode), 32'd1);
    checkOutput("plan1.sel", 32'(sel), 32'd2);
    checkOutput("plan1.hr",  32'(alm_hr), 32'd3);
    applyStimulus("leave", B_C, 0, 0);
    checkOutput("plan1.run_en", 32'(run_en), 32'd1);
    checkOutput("plan1.sel_kept", 32'(sel), 32'd2);

    // Minute and hour wrap
    applyStimulus("enter2", B_C, 0, 0);
    applyStimulus("sel3",   B_R, 0, 0);
    applyStimulus("min_dn", B_D, 0, 0);
    checkOutput("wrap.min59", 32'(alm_min), 32'd59);
    checkOutput("wrap.hr_same", 32'(alm_hr), 32'd3);
    applyStimulus("sel2b", B_L, 0, 0);
    repeat (4) applyStimulus("hr_dn", B_D, 0, 0);
    checkOutput("wrap.hr23", 32'(alm_hr), 32'd23);
    applyStimulus("hr_up23", B_U, 0, 0);
    checkOutput("wrap.hr0", 32'(alm_hr), 32'd0);

    // Clock minute pulse lasts exactly one cycle; center beats up
    applyStimulus("sel1b", B_L, 0, 0);
    applyStimulus("cmin_up", B_U, 0, 0);
    checkOutput("pulse.on", 32'(clk_min_inc), 32'd1);
    applyStimulus("idle", B_NONE, 0, 0);
    checkOutput("pulse.off", 32'(clk_min_inc), 32'd0);
    applyStimulus("c_and_u", B_C | B_U, 0, 0);
    checkOutput("prio.no_inc", 32'(clk_min_inc), 32'd0);
    checkOutput("prio.run", 32'(run_en), 32'd1);

    // Arm, ring, dismiss with left
    applyStimulus("arm", B_U, 0, 0);
    applyStimulus("match", B_NONE, 0, 1);
    checkOutput("ring.on", 32'(ringing), 32'd1);
    applyStimulus("dismiss", B_L, 0, 1);
    checkOutput("ring.off", 32'(ringing), 32'd0);
    checkOutput("ring.en_kept", 32'(alarm_en), 32'd1);
    checkOutput("ring.still_run", 32'(adj_mode), 32'd0);

    // Timeout after RING_SECS ticks, no re-ring while match stays high
    applyStimulus("m_low", B_NONE, 0, 0);
    applyStimulus("m_high", B_NONE, 0, 1);
    applyStimulus("tick1", B_NONE, 1, 1);
    applyStimulus("tick2", B_NONE, 1, 1);
    checkOutput("timeout.before", 32'(ringing), 32'd1);
    applyStimulus("tick3", B_NONE, 1, 1);
    checkOutput("timeout.after", 32'(ringing), 32'd0);
    applyStimulus("hold", B_NONE, 0, 1);
    checkOutput("timeout.no_rering", 32'(ringing), 32'd0);

    // Disarmed and adjust-mode edges do not ring
    applyStimulus("m_low2", B_NONE, 0, 0);
    applyStimulus("disarm", B_D, 0, 0);
    applyStimulus("m_dis", B_NONE, 0, 1);
    checkOutput("disarmed.no_ring", 32'(ringing), 32'd0);
    applyStimulus("m_low3", B_NONE, 0, 0);
    applyStimulus("rearm", B_U, 0, 0);
    applyStimulus("adj_in", B_C, 0, 0);
    applyStimulus("m_adj", B_NONE, 0, 1);
    checkOutput("adjust.no_ring", 32'(ringing), 32'd0);
    applyStimulus("adj_out", B_C, 0, 1);
    applyStimulus("adj_hold", B_NONE, 0, 1);
    checkOutput("leave.no_ring", 32'(ringing), 32'd0);

    // Reset in the middle of adjust
    applyStimulus("m_low4", B_NONE, 0, 0);
    applyStimulus("adj_in2", B_C, 0, 0);
    applyStimulus("sel_mv", B_R, 0, 0);
    asyncReset("midadj");
    checkOutput("midadj.sel0", 32'(sel), 32'd0);

    // Random traffic
    rm = 1'b0;
    for (int i = 0; i < 3000; i++) begin
      rb = B_NONE;
      for (int k = 0; k < 5; k++) begin
        if ($urandom_range(0, 9) == 0) rb[k] = 1'b1;
      end
      if ($urandom_range(0, 11) == 0) rm = ~rm;
      applyStimulus("rand", rb, 1'($urandom_range(0, 3) == 0), rm);
      if (i == 1500) asyncReset("randrst");
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
